// File: rtl/rs_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rs_drive_ctrl
// Purpose  : Command sequencer for a clocked RS flop. It drives mutually
//            exclusive r/s pulses, then reads q_fb back and counts mismatches.
// Revision : 1.0  initial release
// ============================================================================
module rs_drive_ctrl #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    output logic             cmd_ready,
    output logic             r,
    output logic             s,
    input  logic             q_fb,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MAX_PHASE = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int PH_W      = $clog2(MAX_PHASE) + 1;
    localparam logic [PH_W-1:0] DRIVE_LOAD  = PH_W'(PULSE_W - 1);
    localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t          state;
    logic            op_q;
    logic [PH_W-1:0] phase_cnt;
    logic            mismatch;

    assign mismatch = (q_fb != op_q);

    // r and s are only ever loaded as complements or both cleared, so the
    // forbidden r=s=1 combination cannot be produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= 1'b0;
            phase_cnt <= '0;
            cmd_ready <= 1'b1;
            r         <= 1'b0;
            s         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_DRIVE;
                        op_q      <= cmd_op;
                        phase_cnt <= DRIVE_LOAD;
                        cmd_ready <= 1'b0;
                        s         <= cmd_op;
                        r         <= ~cmd_op;
                    end
                end
                ST_DRIVE: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_SETTLE;
                        phase_cnt <= SETTLE_LOAD;
                        r         <= 1'b0;
                        s         <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (phase_cnt == '0) begin
                        state <= ST_CHECK;
                        done  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase

            // A mismatch detected in CHECK takes priority over a clear request.
            if ((state == ST_CHECK) && mismatch) begin
                err <= 1'b1;
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_drive_ctrl
// Purpose  : Directed bench for rs_drive_ctrl with a cycle-age reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_drive_ctrl;

    localparam int PW = 2;
    localparam int ST = 1;
    localparam int CW = 8;
    localparam int CHECK_AGE = PW + ST + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_op = 1'b0;
    logic          cmd_ready;
    logic          r;
    logic          s;
    logic          q_fb;
    logic          done;
    logic          err;
    logic          err_clr = 1'b0;
    logic [CW-1:0] err_cnt;

    int tests = 0;
    int fails = 0;

    rs_drive_ctrl #(.PULSE_W(PW), .SETTLE(ST), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .r         (r),
        .s         (s),
        .q_fb      (q_fb),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Ideal RS flop, optionally overridden to force read-back mismatches
    logic flop_q   = 1'b0;
    logic fb_mode  = 1'b0;
    logic fb_force = 1'b0;
    always @(posedge clk) begin
        if (s)      flop_q <= 1'b1;
        else if (r) flop_q <= 1'b0;
    end
    assign q_fb = fb_mode ? fb_force : flop_q;

    // Reference model: age counts cycles since the accepting edge (0 = idle)
    int age   = 0;
    bit m_op  = 1'b0;
    bit m_err = 1'b0;
    int m_cnt = 0;
    bit mv    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            age   <= 0;
            m_err <= 1'b0;
            m_cnt <= 0;
            mv    <= 1'b1;
        end else if (age == 0) begin
            if (cmd_valid) begin
                age  <= 1;
                m_op <= cmd_op;
            end
            if (err_clr) m_err <= 1'b0;
        end else if (age == CHECK_AGE) begin
            age <= 0;
            if (q_fb != m_op) begin
                m_err <= 1'b1;
                if (m_cnt < 255) m_cnt <= m_cnt + 1;
            end else if (err_clr) begin
                m_err <= 1'b0;
            end
        end else begin
            age <= age + 1;
            if (err_clr) m_err <= 1'b0;
        end
    end

    logic exp_s, exp_r, exp_done, exp_rdy;
    assign exp_s    = (age >= 1) && (age <= PW) && m_op;
    assign exp_r    = (age >= 1) && (age <= PW) && !m_op;
    assign exp_done = (age == CHECK_AGE);
    assign exp_rdy  = (age == 0);

    always @(negedge clk) begin
        if (mv) begin
            tests++;
            if (r !== exp_r || s !== exp_s || done !== exp_done || err !== m_err ||
                int'(err_cnt) != m_cnt || (!rst && cmd_ready !== exp_rdy) || (r & s)) begin
                fails++;
                $display("FAIL model t=%0t got r=%b s=%b done=%b rdy=%b err=%b cnt=%0d expected r=%b s=%b done=%b rdy=%b err=%b cnt=%0d",
                         $time, r, s, done, cmd_ready, err, err_cnt,
                         exp_r, exp_s, exp_done, exp_rdy, m_err, m_cnt);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    bit rec_r[6], rec_s[6], rec_d[6], rec_rdy[6];

    // Issue one command from an idle cycle; returns at the first idle cycle after it
    task automatic cmd(input bit op, input bit mism);
        fb_mode   = mism;
        fb_force  = ~op;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            rec_r[k]   = r;
            rec_s[k]   = s;
            rec_d[k]   = done;
            rec_rdy[k] = cmd_ready;
        end
    endtask

    int acc_idx[$];
    int done_seen;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_r", int'(r), 0);
        chk("reset_s", int'(s), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(cmd_ready), 1);

        // Set command with matching read-back
        cmd(1'b1, 1'b0);
        chk("t1_s_c1", int'(rec_s[1]), 1);
        chk("t1_s_c2", int'(rec_s[2]), 1);
        chk("t1_s_c3", int'(rec_s[3]), 0);
        chk("t1_r_any", int'(rec_r[1] | rec_r[2] | rec_r[3] | rec_r[4]), 0);
        chk("t1_done_c3", int'(rec_d[3]), 0);
        chk("t1_done_c4", int'(rec_d[4]), 1);
        chk("t1_rdy_c4", int'(rec_rdy[4]), 0);
        chk("t1_rdy_c5", int'(rec_rdy[5]), 1);
        chk("t1_err", int'(err), 0);

        // Reset command with q_fb stuck at 1
        cmd(1'b0, 1'b1);
        chk("t2_r_c1", int'(rec_r[1]), 1);
        chk("t2_r_c2", int'(rec_r[2]), 1);
        chk("t2_r_c3", int'(rec_r[3]), 0);
        chk("t2_done_c4", int'(rec_d[4]), 1);
        chk("t2_err", int'(err), 1);
        chk("t2_cnt", int'(err_cnt), 1);

        // Held cmd_valid with alternating op
        fb_mode   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd_op = i[0];
            if (cmd_ready) acc_idx.push_back(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("t3_accepts", acc_idx.size(), 4);
        for (int i = 1; i < acc_idx.size(); i++) chk("t3_gap", acc_idx[i] - acc_idx[i-1], 5);

        // Reset in the middle of a set pulse
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_s_before", int'(s), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_s_after", int'(s), 0);
        chk("t4_r_after", int'(r), 0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_seen |= int'(done);
        end
        chk("t4_no_done", done_seen, 0);
        chk("t4_ready", int'(cmd_ready), 1);
        chk("t4_err", int'(err), 0);
        chk("t4_cnt", int'(err_cnt), 0);

        // Saturation of the mismatch counter
        for (int i = 0; i < 300; i++) cmd(1'b1, 1'b1);
        chk("t5_cnt_sat", int'(err_cnt), 255);
        chk("t5_err", int'(err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", int'(err), 0);
        chk("t5_cnt_kept", int'(err_cnt), 255);

        // Clear request colliding with a mismatching check
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fb_mode   = 1'b1;
        fb_force  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_done", int'(done), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t6_err", int'(err), 1);
        chk("t6_cnt", int'(err_cnt), 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
